sdc_bram_port_arbiter: RTL and testbench
========================================

// Module: sdc_bram_port_arbiter
// PURPOSE
//  Shares port A of the 32x64 dual-port descriptor/data BRAM between two requesters:
//  req0 = host register bus, req1 = SD command/data engine. Round-robin per access.
//  An optional lock gives one requester back-to-back ownership for read-modify-write
//  sequences. A timeout counter breaks a stuck lock. Sits between both requesters and
//  the BRAM instance; port B stays private to the DMA path.
// PARAMETERS
//  DW            64  data width; equals BRAM word width
//  AW            5   address width; 32 words
//  LOCK_TIMEOUT  64  max cycles a lock may be held before forced release (>=2)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  req0/req1  in   1   access request; held until gnt seen
//  lock0/1    in   1   keep ownership after this access; valid with req
//  we0/we1    in   1   1=write, 0=read
//  addr0/1    in   AW  word address
//  wdata0/1   in   DW  write data
//  gnt0/gnt1  out  1   combinational; access performed this cycle
//  rvalid0/1  out  1   registered; rdata valid (read granted previous cycle)
//  rdata0/1   out  DW  = ram_rdata (broadcast; qualify with rvalid)
//  ram_addr   out  AW  to BRAM addr_a
//  ram_wdata  out  DW  to BRAM datain_a
//  ram_wr     out  1   to BRAM wr_a
//  ram_rdata  in   DW  from BRAM dataout_a (1-cycle registered read)
//  clr_err    in   1   clears lock_err
//  lock_err   out  1   sticky; set on lock timeout
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, last_gnt=1 (req0 wins first tie), lock_cnt=0, rvalid0/1=0,
//    lock_err=0, blk0/blk1=0. gnt0/1, ram_wr forced 0 while reset high. BRAM untouched.
//  - At most one gnt per cycle. Mux sel = granted requester; ram_* from it.
//    With no grant: ram_wr=0; ram_addr/ram_wdata hold req0 values (don't-care).
//  - rvalidN <= gntN & ~weN. Read latency 1 cycle. Writes produce no rvalid.
//    Back-to-back reads yield back-to-back rvalid.
//  - IDLE: only one req -> grant it. Both req -> grant ~last_gnt.
//    On grant, last_gnt<=winner. If winner lockN=1 and blkN=0, next state LOCKN,
//    lock_cnt<=0.
//  - LOCKN: only N may be granted (gntN=reqN); other requester stalls.
//    lock_cnt increments every cycle.
//    Sampled lockN=0 -> next IDLE. The other requester is granted no earlier than
//    the next cycle.
//    lock_cnt==LOCK_TIMEOUT-1 with lockN still 1 -> forced release: next IDLE,
//    last_gnt<=N (other wins tie), lock_err<=1, blkN<=1.
//  - blkN: while set, lockN is ignored (grants to N are plain accesses). Clears when
//    lockN is sampled 0.
//  - Simultaneous clr_err and a new timeout: set wins.
//  - lock_cnt width = $clog2(LOCK_TIMEOUT); saturates, never wraps.
//  - Port-A write-through: BRAM returns written data, which is ignored because no
//    rvalid is raised.
//  - Reset mid-lock: immediate IDLE. In-flight rvalid dropped; requester must reissue.
// STRUCTURE
//  - Package sdc_bram_pkg: BRAM_DW=64, BRAM_AW=5, arbiter state localparams
//    (ST_IDLE, ST_LOCK0, ST_LOCK1), default LOCK_TIMEOUT.
//  - One sub-module: sdc_lock_timer (clear/enable, saturating counter, expire pulse).
//  - Remainder (FSM, round-robin pointer, mux, rvalid regs) stays in this file.
// TESTING (BRAM model = 32x64, 1-cycle registered read, write-through)
//  1. reset; req0 write addr 3=64'hDEAD_BEEF_0000_0001, then read addr 3 -> gnt0 both
//     cycles, rvalid0 one cycle after the read grant, rdata0=64'hDEAD_BEEF_0000_0001.
//  2. req0 and req1 reads held 6 cycles -> grants 0,1,0,1,0,1; each rvalid follows
//     its own grant by 1 cycle.
//  3. req0 lock=1 for 4 accesses while req1 held -> gnt1=0 through the lock; gnt1
//     on the cycle after lock0 drops.
//  4. LOCK_TIMEOUT=8; lock1 stuck high, req0 pending -> after 8 lock cycles lock_err=1;
//     next grant is gnt0; further req1 grants do not re-lock until lock1 drops;
//     clr_err clears lock_err.
//  5. Assert reset during LOCK0 with a read in flight -> busy=0, rvalid0=0 next edge,
//     lock_err=0; after release, req1 alone is granted immediately.
//  6. Random 10k-cycle traffic vs. a scoreboard memory -> read data always matches;
//     never two gnts in one cycle; no starvation >2 grants while unlocked.

Source files
------------

// File: rtl/sdc_bram_pkg.sv
// -----------------------------------------------------------------------------
// sdc_bram_pkg
// Shared definitions for the port-A arbiter of the 32x64 descriptor/data BRAM:
//   - BRAM geometry (word width, address width)
//   - arbiter state encodings and the state enum built from them
//   - default lock timeout
//   - rr_pick: round-robin pick between the two requesters
// -----------------------------------------------------------------------------
package sdc_bram_pkg;

    localparam int BRAM_DW          = 64;
    localparam int BRAM_AW          = 5;
    localparam int LOCK_TIMEOUT_DEF = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = ST_IDLE,
        ARB_LOCK0 = ST_LOCK0,
        ARB_LOCK1 = ST_LOCK1
    } arb_state_e;

    // Round-robin pick, returned as {gnt1, gnt0}. With both requesting, the
    // requester that did not win last time gets the port.
    function automatic logic [1:0] rr_pick(input logic req0,
                                           input logic req1,
                                           input logic last_gnt);
        logic [1:0] pick;
        pick = 2'b00;
        if (req0 && req1) begin
            pick = last_gnt ? 2'b01 : 2'b10;
        end else if (req0) begin
            pick = 2'b01;
        end else if (req1) begin
            pick = 2'b10;
        end else begin
            pick = 2'b00;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdc_lock_timer.sv
// -----------------------------------------------------------------------------
// sdc_lock_timer
// Counts how long a lock has been held. The counter is cleared while `clear`
// is high, advances by one each cycle `enable` is high, and saturates at its
// maximum instead of wrapping. `expire` is high in the cycle where the count
// has reached LIMIT-1 while enabled, i.e. in the LIMIT-th enabled cycle.
//
// Ports
//   clk     in  1  system clock
//   reset   in  1  asynchronous, active-high reset
//   clear   in  1  force count to zero
//   enable  in  1  count this cycle
//   expire  out 1  count == LIMIT-1 and enabled
// -----------------------------------------------------------------------------
module sdc_lock_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CW     = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0]   ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]   ONE_C  = CW'(1);
    localparam logic [CW-1:0]   SAT_C  = {CW{1'b1}};
    localparam logic [CW-1:0]   LAST_C = CW'(LIMIT - 1);

    logic [CW-1:0] count_r;

    // Saturating lock-hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= ZERO_C;
        end else if (clear) begin
            count_r <= ZERO_C;
        end else if (enable && (count_r != SAT_C)) begin
            count_r <= count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry flag used by the arbiter in the same cycle.
    always_comb begin
        expire = 1'b0;
        if (enable && (count_r == LAST_C)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

endmodule

// File: rtl/sdc_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdc_bram_port_arbiter
// Shares port A of the 32x64 descriptor/data BRAM between the host register
// bus (requester 0) and the SD command/data engine (requester 1). Plain
// accesses alternate round-robin. A requester may set its lock with a request
// to keep the port for a read-modify-write; a lock held for LOCK_TIMEOUT
// cycles is broken, lock_err is raised and that requester's lock is ignored
// until it drops its lock line.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req0/req1             access request, held until granted
//   lock0/lock1           keep ownership after this access (valid with req)
//   we0/we1               1 = write, 0 = read
//   addr0/addr1 [AW]      word address
//   wdata0/wdata1 [DW]    write data
//   gnt0/gnt1             combinational grant, access happens this cycle
//   rvalid0/rvalid1       registered, read data valid (read granted last cycle)
//   rdata0/rdata1 [DW]    BRAM read data broadcast, qualify with rvalid
//   ram_addr/ram_wdata/ram_wr   to BRAM port A
//   ram_rdata [DW]        from BRAM port A (1-cycle registered read)
//   clr_err               clears lock_err
//   lock_err              sticky, set on lock timeout
//   busy                  arbiter is in a locked state
// -----------------------------------------------------------------------------
module sdc_bram_port_arbiter
    import sdc_bram_pkg::*;
#(
    parameter int DW           = BRAM_DW,
    parameter int AW           = BRAM_AW,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wr,
    input  logic [DW-1:0] ram_rdata,
    input  logic          clr_err,
    output logic          lock_err,
    output logic          busy
);

    arb_state_e  state_r;
    logic        last_gnt_r;     // 0: requester 0 won last, 1: requester 1
    logic        blk0_r;
    logic        blk1_r;
    logic        rvalid0_r;
    logic        rvalid1_r;
    logic        lock_err_r;

    logic [1:0]  pick_s;         // {gnt1, gnt0}
    logic        expire_s;
    logic        timeout0_s;
    logic        timeout1_s;
    logic        idle_s;

    // Lock-hold timer: held at zero in IDLE, counts every locked cycle.
    sdc_lock_timer #(
        .LIMIT  (LOCK_TIMEOUT)
    ) u_lock_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (idle_s),
        .enable (~idle_s),
        .expire (expire_s)
    );

    // State decode and forced-release detection for the current cycle.
    always_comb begin
        idle_s     = (state_r == ARB_IDLE);
        timeout0_s = 1'b0;
        timeout1_s = 1'b0;
        if ((state_r == ARB_LOCK0) && lock0 && expire_s) begin
            timeout0_s = 1'b1;
        end else if ((state_r == ARB_LOCK1) && lock1 && expire_s) begin
            timeout1_s = 1'b1;
        end else begin
            timeout0_s = 1'b0;
            timeout1_s = 1'b0;
        end
    end

    // Grant selection. A locked state only serves its owner; the other side
    // stalls until the state machine is back in IDLE.
    always_comb begin
        pick_s = 2'b00;
        if (reset) begin
            pick_s = 2'b00;
        end else begin
            case (state_r)
                ARB_IDLE:  pick_s = rr_pick(req0, req1, last_gnt_r);
                ARB_LOCK0: pick_s = {1'b0, req0};
                ARB_LOCK1: pick_s = {req1, 1'b0};
                default:   pick_s = 2'b00;
            endcase
        end
    end

    // Port-A mux. Without a grant the address/data follow requester 0 and the
    // write strobe stays low.
    always_comb begin
        ram_addr  = addr0;
        ram_wdata = wdata0;
        ram_wr    = 1'b0;
        if (pick_s[1]) begin
            ram_addr  = addr1;
            ram_wdata = wdata1;
            ram_wr    = we1;
        end else begin
            ram_addr  = addr0;
            ram_wdata = wdata0;
            ram_wr    = pick_s[0] & we0;
        end
    end

    // Arbiter FSM with round-robin pointer, lock blockers, error flag and
    // read-valid pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ARB_IDLE;
            last_gnt_r <= 1'b1;
            blk0_r     <= 1'b0;
            blk1_r     <= 1'b0;
            rvalid0_r  <= 1'b0;
            rvalid1_r  <= 1'b0;
            lock_err_r <= 1'b0;
        end else begin
            rvalid0_r <= pick_s[0] & ~we0;
            rvalid1_r <= pick_s[1] & ~we1;

            // A forced release hands the tie-break to the other requester.
            if (timeout0_s) begin
                last_gnt_r <= 1'b0;
            end else if (timeout1_s) begin
                last_gnt_r <= 1'b1;
            end else if (pick_s[0]) begin
                last_gnt_r <= 1'b0;
            end else if (pick_s[1]) begin
                last_gnt_r <= 1'b1;
            end else begin
                last_gnt_r <= last_gnt_r;
            end

            // Blockers hold until the owner lets go of its lock line.
            if (timeout0_s) begin
                blk0_r <= 1'b1;
            end else if (!lock0) begin
                blk0_r <= 1'b0;
            end else begin
                blk0_r <= blk0_r;
            end

            if (timeout1_s) begin
                blk1_r <= 1'b1;
            end else if (!lock1) begin
                blk1_r <= 1'b0;
            end else begin
                blk1_r <= blk1_r;
            end

            // A new timeout beats a simultaneous clear.
            if (timeout0_s || timeout1_s) begin
                lock_err_r <= 1'b1;
            end else if (clr_err) begin
                lock_err_r <= 1'b0;
            end else begin
                lock_err_r <= lock_err_r;
            end

            case (state_r)
                ARB_IDLE: begin
                    if (pick_s[0] && lock0 && !blk0_r) begin
                        state_r <= ARB_LOCK0;
                    end else if (pick_s[1] && lock1 && !blk1_r) begin
                        state_r <= ARB_LOCK1;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_LOCK0: begin
                    if (!lock0 || expire_s) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_LOCK0;
                    end
                end
                ARB_LOCK1: begin
                    if (!lock1 || expire_s) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_LOCK1;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

    assign gnt0     = pick_s[0];
    assign gnt1     = pick_s[1];
    assign rvalid0  = rvalid0_r;
    assign rvalid1  = rvalid1_r;
    assign rdata0   = ram_rdata;
    assign rdata1   = ram_rdata;
    assign lock_err = lock_err_r;
    assign busy     = (state_r != ARB_IDLE);

endmodule

// File: tb/tb_sdc_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdc_bram_port_arbiter
// Directed cycle table for the arbiter (LOCK_TIMEOUT = 8) with a 32x64 BRAM
// model (1-cycle registered read, write-through), followed by a reset-in-lock
// sequence and random unlocked traffic checked against a scoreboard memory.
// Table pre-edge fields are the grants seen during the cycle; post-edge fields
// are rvalid/busy/lock_err (and rdata when rvalid) just after the closing edge.
// -----------------------------------------------------------------------------
module tb_sdc_bram_port_arbiter;

    localparam logic [63:0] DA = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
    localparam logic [63:0] DC = 64'h1111_2222_3333_4444;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [4:0]  addr0, addr1;
    logic [63:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [63:0] rdata0, rdata1;
    logic [4:0]  ram_addr;
    logic [63:0] ram_wdata;
    logic        ram_wr;
    logic [63:0] ram_rdata;
    logic        clr_err, lock_err, busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  in_b;   // {req0, req1, lock0, lock1, we0, we1}
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        clr;
        logic [5:0]  exp_b;  // {gnt0, gnt1, rvalid0, rvalid1, busy, lock_err}
        logic [63:0] erd;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    sdc_bram_port_arbiter #(
        .DW           (64),
        .AW           (5),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .lock0     (lock0),
        .lock1     (lock1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wr    (ram_wr),
        .ram_rdata (ram_rdata),
        .clr_err   (clr_err),
        .lock_err  (lock_err),
        .busy      (busy)
    );

    // BRAM port A model: registered read, written data returned on writes.
    logic [63:0] mem [0:31] = '{default: 64'd0};
    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr] <= ram_wdata;
            ram_rdata     <= ram_wdata;
        end else begin
            ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] ib, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic clr,
                       input logic [5:0] eb, input logic [63:0] erd);
        vec_t t;
        t.in_b = ib; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.clr = clr; t.exp_b = eb; t.erd = erd;
        tbl.push_back(t);
    endtask

    initial begin
        vec_t        v;
        logic [63:0] sb [0:31];
        bit          p0, p1, rw0, rw1, mlast, eg0, eg1, erv0, erv1;
        logic [4:0]  ra0, ra1;
        logic [63:0] rd0, rd1, ed0, ed1;
        int          starve0, starve1;

        // ---------------- reset state ----------------
        reset = 1'b1; req0 = 1'b1; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        we0 = 1'b1; we1 = 1'b0; addr0 = 5'd3; addr1 = 5'd0;
        wdata0 = 64'hFFFF_FFFF_FFFF_FFFF; wdata1 = 64'd0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk1("reset gnt0", gnt0, 1'b0);
        chk1("reset ram_wr", ram_wr, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset lock_err", lock_err, 1'b0);
        chk1("reset rvalid0", rvalid0, 1'b0);
        chk1("reset rvalid1", rvalid1, 1'b0);
        req0 = 1'b0; we0 = 1'b0; reset = 1'b0;

        // ---------------- directed table ----------------
        // write then read addr 3 by requester 0
        add(6'b100010, 5'd3, 5'd0, DA, 64'd0, 1'b0, 6'b100000, 64'd0);
        add(6'b100000, 5'd3, 5'd0, 64'd0, 64'd0, 1'b0, 6'b101000, DA);
        // preload addr 4 (req0) and addr 5 (req1)
        add(6'b100010, 5'd4, 5'd0, DB, 64'd0, 1'b0, 6'b100000, 64'd0);
        add(6'b010001, 5'd0, 5'd5, 64'd0, DC, 1'b0, 6'b010000, 64'd0);
        // both reading for 6 cycles: alternate starting with requester 0
        for (int k = 0; k < 6; k++) begin
            if ((k % 2) == 0) add(6'b110000, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b101000, DB);
            else              add(6'b110000, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010100, DC);
        end
        // requester 0 locked for 4 accesses, requester 1 stalls
        for (int k = 0; k < 4; k++)
            add(6'b111000, 5'd3, 5'd5, 64'd0, 64'd0, 1'b0, 6'b101010, DA);
        add(6'b010000, 5'd3, 5'd5, 64'd0, 64'd0, 1'b0, 6'b000000, 64'd0);
        add(6'b010000, 5'd3, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010100, DC);
        // requester 1 lock stuck: 8 locked cycles, then forced release
        add(6'b010100, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010110, DC);
        for (int k = 0; k < 7; k++)
            add(6'b110100, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010110, DC);
        add(6'b110100, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010101, DC);
        // requester 0 wins next; requester 1 does not re-lock while blocked
        for (int k = 0; k < 2; k++) begin
            add(6'b110100, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b101001, DB);
            add(6'b110100, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010101, DC);
        end
        // lock1 drops (blocker clears), then relock works; clr_err clears flag
        add(6'b010000, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010101, DC);
        add(6'b010100, 5'd4, 5'd5, 64'd0, 64'd0, 1'b1, 6'b010110, DC);
        add(6'b010000, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010100, DC);
        // second timeout with clr_err on the expiring cycle: set wins
        add(6'b010100, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010110, DC);
        for (int k = 0; k < 7; k++)
            add(6'b010100, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010110, DC);
        add(6'b010100, 5'd4, 5'd5, 64'd0, 64'd0, 1'b1, 6'b010101, DC);
        add(6'b010000, 5'd4, 5'd5, 64'd0, 64'd0, 1'b0, 6'b010101, DC);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            {req0, req1, lock0, lock1, we0, we1} = v.in_b;
            addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1; clr_err = v.clr;
            #1;
            chk1($sformatf("v%0d gnt0", i), gnt0, v.exp_b[5]);
            chk1($sformatf("v%0d gnt1", i), gnt1, v.exp_b[4]);
            @(posedge clk); #1;
            chk1($sformatf("v%0d rvalid0", i), rvalid0, v.exp_b[3]);
            chk1($sformatf("v%0d rvalid1", i), rvalid1, v.exp_b[2]);
            chk1($sformatf("v%0d busy", i), busy, v.exp_b[1]);
            chk1($sformatf("v%0d lock_err", i), lock_err, v.exp_b[0]);
            if (v.exp_b[3]) chk64($sformatf("v%0d rdata0", i), rdata0, v.erd);
            if (v.exp_b[2]) chk64($sformatf("v%0d rdata1", i), rdata1, v.erd);
        end

        // ---------------- reset during LOCK0 with a read in flight ----------------
        @(negedge clk);
        req0 = 1'b1; lock0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
        req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0; clr_err = 1'b0;
        #1;
        chk1("lockrst gnt0", gnt0, 1'b1);
        @(posedge clk); #1;
        chk1("lockrst busy pre", busy, 1'b1);
        chk1("lockrst rvalid0 pre", rvalid0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("lockrst gnt0 forced", gnt0, 1'b0);
        chk1("lockrst ram_wr forced", ram_wr, 1'b0);
        @(posedge clk); #1;
        chk1("lockrst busy", busy, 1'b0);
        chk1("lockrst rvalid0", rvalid0, 1'b0);
        chk1("lockrst lock_err", lock_err, 1'b0);
        @(negedge clk);
        reset = 1'b0; req0 = 1'b0; lock0 = 1'b0; req1 = 1'b1; addr1 = 5'd5;
        #1;
        chk1("postrst gnt1", gnt1, 1'b1);
        chk1("postrst gnt0", gnt0, 1'b0);
        @(posedge clk); #1;
        chk1("postrst rvalid1", rvalid1, 1'b1);
        chk64("postrst rdata1", rdata1, DC);
        @(negedge clk);
        req1 = 1'b0;

        // ---------------- random unlocked traffic ----------------
        for (int i = 0; i < 32; i++) sb[i] = 64'd0;
        sb[3] = DA; sb[4] = DB; sb[5] = DC;
        p0 = 1'b0; p1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0; mlast = 1'b1;
        ra0 = 5'd0; ra1 = 5'd0; rd0 = 64'd0; rd1 = 64'd0;
        starve0 = 0; starve1 = 0;
        for (int cyc = 0; cyc < 10000 && bad < 50; cyc++) begin
            @(negedge clk);
            if (!p0 && ($urandom_range(0, 1) == 1)) begin
                p0 = 1'b1; rw0 = ($urandom_range(0, 1) == 1);
                ra0 = 5'($urandom_range(0, 31)); rd0 = {$urandom, $urandom};
            end
            if (!p1 && ($urandom_range(0, 1) == 1)) begin
                p1 = 1'b1; rw1 = ($urandom_range(0, 1) == 1);
                ra1 = 5'($urandom_range(0, 31)); rd1 = {$urandom, $urandom};
            end
            req0 = p0; we0 = rw0; addr0 = ra0; wdata0 = rd0;
            req1 = p1; we1 = rw1; addr1 = ra1; wdata1 = rd1;
            lock0 = 1'b0; lock1 = 1'b0; clr_err = 1'b0;
            #1;
            eg0 = p0 && (!p1 || mlast);
            eg1 = p1 && (!p0 || !mlast);
            chk1($sformatf("rnd%0d gnt0", cyc), gnt0, eg0);
            chk1($sformatf("rnd%0d gnt1", cyc), gnt1, eg1);
            chk1($sformatf("rnd%0d onehot", cyc), gnt0 & gnt1, 1'b0);
            if (gnt0) starve0 = 0;
            else if (p0 && gnt1) begin
                starve0++;
                chk1($sformatf("rnd%0d starve0", cyc), starve0 > 2, 1'b0);
            end
            if (gnt1) starve1 = 0;
            else if (p1 && gnt0) begin
                starve1++;
                chk1($sformatf("rnd%0d starve1", cyc), starve1 > 2, 1'b0);
            end
            @(posedge clk);
            erv0 = eg0 && !rw0; ed0 = sb[ra0];
            erv1 = eg1 && !rw1; ed1 = sb[ra1];
            if (eg0 && rw0) sb[ra0] = rd0;
            if (eg1 && rw1) sb[ra1] = rd1;
            if (eg0) begin mlast = 1'b0; p0 = 1'b0; end
            if (eg1) begin mlast = 1'b1; p1 = 1'b0; end
            #1;
            chk1($sformatf("rnd%0d rvalid0", cyc), rvalid0, erv0);
            chk1($sformatf("rnd%0d rvalid1", cyc), rvalid1, erv1);
            if (erv0) chk64($sformatf("rnd%0d rdata0", cyc), rdata0, ed0);
            if (erv1) chk64($sformatf("rnd%0d rdata1", cyc), rdata1, ed1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
